// File: rtl/mul4x4_4x1_driver.sv
// rtl/mul4x4_4x1_driver.sv - operand streamer and result collector for the 4x4 x 4x1 float32 wrapper
module mul4x4_4x1_driver #(
  parameter int TIMEOUT = 4096
) (
  input  logic         iClk,
  input  logic         iRstn,
  input  logic         cfg_we,
  input  logic [4:0]   cfg_addr,
  input  logic [31:0]  cfg_wdata,
  input  logic         start,
  output logic         busy,
  output logic         res_valid,
  output logic [127:0] res_data,
  input  logic         res_ack,
  output logic         proto_err,
  input  logic         mv_ready,
  output logic         mv_data_valid,
  output logic [31:0]  mv_data,
  input  logic         mv_calc_done,
  input  logic [31:0]  mv_result,
  output logic         mv_read_done
);
  localparam logic [15:0] TO = 16'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_WAKE, S_SEND, S_WAIT, S_COLLECT, S_RELEASE, S_PRESENT, S_ABORT
  } state_t;

  state_t      state, state_nx;
  logic [31:0] opbuf [20];
  logic [31:0] part [3];
  logic [15:0] idx;
  logic [15:0] wdog;
  logic [1:0]  slot;
  logic        last_beat;
  logic        timed_out;
  logic        capture;

  assign last_beat = (idx == 16'd19);
  // wdog equals the number of WAIT cycles already completed, so TIMEOUT caps the WAIT dwell
  assign timed_out = (TO != 16'd0) && (wdog == TO - 16'd1);
  assign capture   = (state == S_WAIT || state == S_COLLECT) && mv_calc_done;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (start && mv_ready) state_nx = S_WAKE;
      S_WAKE:    state_nx = S_SEND;
      S_SEND:    if (last_beat) state_nx = S_WAIT;
      S_WAIT: begin
        if (mv_calc_done)   state_nx = S_COLLECT;
        else if (timed_out) state_nx = S_ABORT;
      end
      S_COLLECT: begin
        if (!mv_calc_done)       state_nx = S_ABORT;
        else if (slot == 2'd3)   state_nx = S_RELEASE;
      end
      S_RELEASE: state_nx = S_PRESENT;
      S_PRESENT: if (res_ack) state_nx = S_IDLE;
      S_ABORT:   state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  assign busy          = (state != S_IDLE);
  assign res_valid     = (state == S_PRESENT);
  assign proto_err     = (state == S_ABORT);
  assign mv_read_done  = (state == S_RELEASE) || (state == S_ABORT);
  assign mv_data_valid = (state == S_WAKE) || (state == S_SEND);
  assign mv_data       = (state == S_SEND) ? opbuf[idx[4:0]] : 32'd0;

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      state    <= S_IDLE;
      idx      <= '0;
      wdog     <= '0;
      slot     <= '0;
      res_data <= '0;
      for (int i = 0; i < 20; i++) opbuf[i] <= '0;
      for (int i = 0; i < 3; i++)  part[i]  <= '0;
    end else begin
      state <= state_nx;

      if (state == S_IDLE && cfg_we && cfg_addr < 5'd20)
        opbuf[cfg_addr] <= cfg_wdata;

      idx <= (state == S_SEND && !last_beat) ? idx + 16'd1 : 16'd0;

      if (state == S_WAIT && state_nx == S_WAIT) begin
        if (wdog != 16'hFFFF) wdog <= wdog + 16'd1;
      end else begin
        wdog <= '0;
      end

      // partial words stay private so an aborted burst never disturbs the presented result
      if (capture) begin
        if (slot == 2'd3) res_data <= {mv_result, part[2], part[1], part[0]};
        else              part[slot] <= mv_result;
        slot <= slot + 2'd1;
      end else begin
        slot <= '0;
      end
    end
  end
endmodule

// File: tb/tb_mul4x4_4x1_driver.sv
// tb/tb_mul4x4_4x1_driver.sv - randomized self-checking bench for mul4x4_4x1_driver
module tb_mul4x4_4x1_driver;
  logic         iClk = 1'b0;
  logic         iRstn = 1'b0;
  logic         cfg_we = 1'b0;
  logic [4:0]   cfg_addr = '0;
  logic [31:0]  cfg_wdata = '0;
  logic         start = 1'b0;
  logic         busy;
  logic         res_valid;
  logic [127:0] res_data;
  logic         res_ack = 1'b0;
  logic         proto_err;
  logic         mv_ready = 1'b1;
  logic         mv_data_valid;
  logic [31:0]  mv_data;
  logic         mv_calc_done = 1'b0;
  logic [31:0]  mv_result = '0;
  logic         mv_read_done;

  int tests = 0;
  int fails = 0;
  int model [20];
  logic [127:0] last_res = '0;

  mul4x4_4x1_driver #(.TIMEOUT(8)) dut (
    .iClk(iClk), .iRstn(iRstn),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .start(start), .busy(busy),
    .res_valid(res_valid), .res_data(res_data), .res_ack(res_ack),
    .proto_err(proto_err),
    .mv_ready(mv_ready), .mv_data_valid(mv_data_valid), .mv_data(mv_data),
    .mv_calc_done(mv_calc_done), .mv_result(mv_result), .mv_read_done(mv_read_done)
  );

  always #5 iClk = ~iClk;

  function automatic logic [31:0] f32_of(input int n);
    int e;
    logic [31:0] m;
    if (n <= 0) return 32'h0;
    e = 0;
    for (int b = 0; b < 24; b++) if (n >= (1 << b)) e = b;
    m = 32'(n) << (23 - e);
    return {1'b0, 8'(127 + e), m[22:0]};
  endfunction

  function automatic int int_of(input logic [31:0] f);
    int e;
    logic [31:0] m;
    if (f[30:23] == 8'd0) return 0;
    e = int'(f[30:23]) - 127;
    if (e < 0 || e > 23) return 0;
    m = {8'd0, 1'b1, f[22:0]};
    return int'(m >> (23 - e));
  endfunction

  function automatic logic [127:0] model_result();
    logic [127:0] r;
    int s;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      s = 0;
      for (int j = 0; j < 4; j++) s += model[4*i+j] * model[16+j];
      r[32*i +: 32] = f32_of(s);
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_model();
    for (int i = 0; i < 20; i++) begin
      @(negedge iClk);
      cfg_we = 1'b1; cfg_addr = 5'(i); cfg_wdata = f32_of(model[i]);
    end
    @(negedge iClk);
    cfg_we = 1'b1; cfg_addr = 5'd25; cfg_wdata = 32'hDEADBEEF;
    @(negedge iClk);
    cfg_we = 1'b0;
  endtask

  task automatic randomize_model();
    for (int i = 0; i < 20; i++) model[i] = int'($urandom_range(0, 7));
  endtask

  // One transaction with a behavioural wrapper: it collects the stream, multiplies, and returns rows.
  task automatic run_txn(input string tag, input int lat, input int ndone, input int ack_wait,
                         input bit poke, input bit late_wr, input bit start_present);
    logic [31:0]  beats [$];
    logic [127:0] exp_res, held;
    int first_v, rd_cnt, rd_at, pe_cnt, pe_at, rv_cnt, rv_first, unstable, bad_beats;
    int c_cyc, abort_at, cyc, k, y, wr_val;
    bit done;
    beats.delete();
    first_v = -1; rd_cnt = 0; rd_at = -1; pe_cnt = 0; pe_at = -1;
    rv_cnt = 0; rv_first = -1; unstable = 0; bad_beats = 0; held = '0;
    c_cyc = 22 + lat;
    abort_at = (ndone == 0) ? 30 : c_cyc + ndone + 1;

    @(negedge iClk);
    mv_ready = 1'b1;
    start = 1'b1;
    if (late_wr) begin
      wr_val = int'($urandom_range(1, 7));
      model[19] = wr_val;
      cfg_we = 1'b1; cfg_addr = 5'd19; cfg_wdata = f32_of(wr_val);
    end
    exp_res = model_result();

    done = 1'b0;
    cyc = 0;
    while (!done && cyc < 200) begin
      @(negedge iClk);
      cyc++;
      cfg_we = 1'b0;
      if (cyc == 1) check({tag, " busy_up"}, busy, 1);
      if (mv_data_valid) begin
        if (first_v < 0) first_v = cyc;
        beats.push_back(mv_data);
      end
      if (mv_read_done) begin rd_cnt++; rd_at = cyc; end
      if (proto_err)    begin pe_cnt++; pe_at = cyc; end
      if (res_valid) begin
        if (rv_cnt == 0) begin rv_first = cyc; held = res_data; end
        else if (res_data !== held) unstable++;
        rv_cnt++;
      end
      if (poke && cyc == 5) begin
        cfg_we = 1'b1; cfg_addr = 5'd0; cfg_wdata = 32'h41000000;
      end
      start = start_present && rv_cnt >= 2 && rv_cnt <= 4;
      mv_calc_done = (ndone > 0 && cyc >= c_cyc && cyc < c_cyc + ndone);
      mv_result = '0;
      if (mv_calc_done && beats.size() == 21) begin
        k = cyc - c_cyc;
        y = 0;
        for (int j = 0; j < 4; j++) y += int_of(beats[1+4*k+j]) * int_of(beats[17+j]);
        mv_result = f32_of(y);
      end
      res_ack = res_valid && (rv_cnt == ack_wait + 1);
      if (cyc > 1 && !busy) done = 1'b1;
    end
    start = 1'b0; res_ack = 1'b0; mv_calc_done = 1'b0;

    check({tag, " finished"}, done, 1);
    check({tag, " first_valid"}, first_v, 1);
    check({tag, " burst_len"}, beats.size(), 21);
    for (int i = 0; i < beats.size() && i < 21; i++)
      if (beats[i] !== ((i == 0) ? 32'h0 : f32_of(model[i-1]))) bad_beats++;
    check({tag, " beat_errors"}, bad_beats, 0);
    check({tag, " read_done_count"}, rd_cnt, 1);
    if (ndone >= 4) begin
      check({tag, " read_done_cycle"}, rd_at, c_cyc + 4);
      check({tag, " proto_err_count"}, pe_cnt, 0);
      check({tag, " res_valid_first"}, rv_first, c_cyc + 5);
      check({tag, " res_valid_len"}, rv_cnt, ack_wait + 1);
      check({tag, " res_unstable"}, unstable, 0);
      check({tag, " res_data"}, held, exp_res);
      check({tag, " res_data_hold"}, res_data, exp_res);
      last_res = exp_res;
    end else begin
      check({tag, " proto_err_count"}, pe_cnt, 1);
      check({tag, " proto_err_cycle"}, pe_at, abort_at);
      check({tag, " read_done_cycle"}, rd_at, abort_at);
      check({tag, " res_valid_count"}, rv_cnt, 0);
      check({tag, " res_data_kept"}, res_data, last_res);
    end
  endtask

  initial begin
    for (int i = 0; i < 20; i++) model[i] = 0;
    #12;
    check("reset ctrl", {busy, res_valid, proto_err, mv_data_valid, mv_read_done, mv_data}, '0);
    check("reset res_data", res_data, '0);
    @(negedge iClk);
    iRstn = 1'b1;

    for (int i = 0; i < 16; i++) model[i] = (i % 5 == 0) ? 1 : 0;
    for (int j = 0; j < 4; j++) model[16+j] = j + 1;
    load_model();
    run_txn("identity", 3, 4, 0, 1'b0, 1'b0, 1'b0);
    check("identity literal", res_data,
          {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000});

    for (int t = 0; t < 3; t++) begin
      randomize_model();
      load_model();
      run_txn("random", int'($urandom_range(0, 6)), 4, int'($urandom_range(0, 3)),
              1'b0, 1'b0, 1'b0);
    end

    randomize_model();
    load_model();
    run_txn("locked_buf", 1, 4, 1, 1'b1, 1'b0, 1'b0);
    run_txn("late_write", 2, 4, 0, 1'b0, 1'b1, 1'b0);

    mv_ready = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge iClk);
      check("start_no_ready busy", busy, 0);
    end
    start = 1'b0;
    mv_ready = 1'b1;
    @(negedge iClk);
    check("start_no_ready after", busy, 0);

    run_txn("watchdog", 0, 0, 0, 1'b0, 1'b0, 1'b0);
    run_txn("short_burst", 2, 2, 0, 1'b0, 1'b0, 1'b0);

    randomize_model();
    load_model();
    run_txn("backpressure", 4, 4, 10, 1'b0, 1'b0, 1'b1);
    check("backpressure idle", busy, 0);

    @(negedge iClk);
    start = 1'b1;
    @(negedge iClk);
    start = 1'b0;
    repeat (6) @(negedge iClk);
    check("mid_send valid", mv_data_valid, 1);
    #2 iRstn = 1'b0;
    #1;
    check("async reset ctrl", {busy, res_valid, proto_err, mv_data_valid, mv_read_done, mv_data}, '0);
    check("async reset res_data", res_data, '0);
    @(negedge iClk);
    iRstn = 1'b1;
    for (int i = 0; i < 20; i++) model[i] = 0;
    last_res = '0;

    randomize_model();
    load_model();
    run_txn("after_reset", 5, 4, 2, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mul4x4_4x1_driver.md
# mul4x4_4x1_driver

Initiator-side controller for the 4x4-matrix × 4x1-vector float32 compute wrapper. Software or a host FSM preloads 16 matrix words and 4 vector words into a local operand buffer, then pulses `start`. The driver streams the operands into the wrapper's `ready`/`data_valid`/`data` load port, collects the four `calc_done`/`result` words, and releases the wrapper with `read_done`. It presents the four results as one packed word on a valid/ack port.

## Interface
- `TIMEOUT`, 4096: maximum number of cycles in WAIT_CALC before aborting. 0 disables the watchdog. Range 0..65535.
- `iClk` in 1: clock.
- `iRstn` in 1: asynchronous, active-low reset. Single clock domain; asserts asynchronously, released synchronously by the integrator.
- `cfg_we` in 1: operand buffer write strobe.
- `cfg_addr` in 5: buffer address.
  - 0..15 are matrix words in row-major order (row*4+col).
  - 16..19 are vector elements 0..3.
  - 20..31 are ignored.
- `cfg_wdata` in 32: operand word (IEEE-754 single).
- `start` in 1: request a computation.
- `busy` out 1: high in every state except IDLE.
- `res_valid` out 1: packed result is available.
- `res_data` out 128: result i occupies bits [32i+31:32i].
- `res_ack` in 1: consumer accepts the result.
- `proto_err` out 1: one-cycle pulse on an abort.
- `mv_ready` in 1: wrapper's `ready`.
- `mv_data_valid` out 1: drives the wrapper's `data_valid`.
- `mv_data` out 32: drives the wrapper's `data`.
- `mv_calc_done` in 1: wrapper's `calc_done`.
- `mv_result` in 32: wrapper's `result`.
- `mv_read_done` out 1: drives the wrapper's `read_done`.

## Operation
- **Reset values:** state IDLE; `busy`, `res_valid`, `proto_err`, `mv_data_valid`, `mv_read_done` = 0; `mv_data` = 0; `res_data` = 0; operand buffer = 0; all counters = 0.
- **Buffer writes:** accepted only in IDLE. While `busy` is high, `cfg_we` is ignored, so the operands are frozen for the whole transaction.
- **IDLE:**
  - `start` && `mv_ready` → WAKE.
  - `start` with `mv_ready` low is ignored, not queued. The requester holds `start` until `busy` rises.
- **WAKE (1 cycle):** `mv_data_valid`=1, `mv_data`=0. This is the wake beat; the wrapper discards it. → SEND.
- **SEND (20 cycles):**
  - `mv_data_valid`=1 continuously, with no gaps allowed.
  - `mv_data` = buffer[idx] for idx 0..19 (16 matrix words, then 4 vector words).
  - idx==19 → WAIT_CALC; idx clears.
- **WAIT_CALC:**
  - `mv_data_valid`=0 and `mv_data`=0.
  - Watchdog counts up each cycle.
  - `mv_calc_done` → COLLECT. Capture `mv_result` into slot 0 in this same cycle; the wrapper's result is valid in the cycle `calc_done` is high.
  - Watchdog == `TIMEOUT` (when `TIMEOUT` ≠ 0) → ABORT.
- **COLLECT:**
  - Each cycle with `mv_calc_done`=1, capture `mv_result` into the next slot.
  - After slot 3 is captured → RELEASE.
  - `mv_calc_done`=0 before 4 words are captured → ABORT.
- **RELEASE (1 cycle):** `mv_read_done`=1. → PRESENT.
- **PRESENT:**
  - `res_valid`=1 and `res_data` is stable.
  - `res_ack` → IDLE; `res_valid` falls in the next cycle.
  - `start` is ignored in this state.
- **ABORT (1 cycle):** `proto_err`=1 and `mv_read_done`=1. → IDLE; `res_valid` is never raised.
- `res_data` holds its last value until the next successful capture overwrites it.

## Timing
- `start` sampled at edge T:
  - WAKE beat during T+1.
  - Matrix words during T+2..T+17.
  - Vector words during T+18..T+21.
  - `mv_data_valid` low from T+22.
- Latency from first `calc_done` cycle C:
  - Result slots 0..3 captured at the ends of C..C+3.
  - `mv_read_done` during C+4.
  - `res_valid` from C+5.
- Simultaneous `cfg_we` and `start` in IDLE: the write takes effect and the transaction sends the new value.
- Asynchronous reset mid-operation forces all reset values immediately. The wrapper shares the reset, so no drain is required.
- Watchdog and idx counters are 16 bits and never wrap: both clear on state exit.

## Test plan
- **Identity matrix:** buffer holds identity (0x3F800000 on the diagonal, 0 elsewhere) and vector [0x3F800000, 0x40000000, 0x40400000, 0x40800000]; `start` → `res_data` = {0x40800000, 0x40400000, 0x40000000, 0x3F800000}, `res_valid` high.
- **Stream timing:** check a contiguous 21-cycle `mv_data_valid` burst, beat 0 = 0, beats 1..20 = buffer[0..19]. Check a single-cycle `mv_read_done` exactly 4 cycles after the first `calc_done`.
- **Locked buffer and start guards:**
  - `cfg_we` addr 0 data 0x41000000 during SEND → ignored; result unchanged.
  - `start` while `mv_ready`=0 → `busy` stays 0.
- **Watchdog:** `TIMEOUT`=8 with a stub that never raises `calc_done` → `proto_err` pulse 8 cycles after WAIT_CALC entry, one `mv_read_done` pulse, back in IDLE, `res_valid` never asserts.
- **Short result burst:** stub raises `calc_done` for only 2 cycles → `proto_err` on the 3rd cycle, return to IDLE.
- **Back-pressure and reset:**
  - `res_ack` withheld 10 cycles → `res_valid` and `res_data` stable; a `start` issued during that window is ignored.
  - Reset asserted mid-SEND → all outputs 0 asynchronously.
  - A clean transaction after reset release passes.
